// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N counter family.
//   count_mode_e : behaviour when a step lands at end of travel
//                  (MODE_WRAP wraps around, MODE_SAT holds at the end value)
//   clog2_min1   : register width for a 0..n-1 range, never less than 1 bit
package counter_pkg;

  typedef enum logic {MODE_WRAP, MODE_SAT} count_mode_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler that turns enabled cycles into one step every DIV enabled cycles.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low; clears the phase counter
//   en   : advance the phase; phase holds while low
//   clr  : restart the period (driven by the parent's parallel load)
//   step : one-cycle pulse on the last enabled cycle of each period
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  // A load cycle never steps, so clr masks the pulse as well as restarting.
  assign step = en & ~clr & (pre == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LAST) ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with prescaler, parallel load and wrap/saturate
// end mode.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-low
//   en       : count enable, gates the prescaler
//   up       : 1 = increment, 0 = decrement (used on the next step)
//   load     : parallel load strobe, overrides stepping and ignores en
//   load_val : value to load, clamped to N-1
//   count    : registered count, 0..N-1
//   tc       : combinational terminal count, step taken at end of travel
//   ovf      : sticky flag, set by the first wrap/saturation, cleared by load
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int          N    = 4,
  parameter int          DIV  = 1,
  parameter count_mode_e MODE = MODE_WRAP,
  localparam int         W    = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_CNT = W'(N - 1);

  logic         step;
  logic         at_end;
  logic [W-1:0] load_clamped;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  // Clamping is only reachable when N is not a power of two.
  if ((1 << W) > N) begin : g_clamp
    assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;
  end else begin : g_noclamp
    assign load_clamped = load_val;
  end

  assign at_end = up ? (count == MAX_CNT) : (count == '0);
  assign tc     = step & at_end & rst;

  // Wrap uses explicit end compares rather than natural W-bit overflow so
  // that non-power-of-two moduli wrap at N-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      ovf   <= 1'b0;
    end else if (step) begin
      if (at_end) begin
        ovf <= 1'b1;
        if (MODE == MODE_WRAP) begin
          count <= up ? '0 : MAX_CNT;
        end
      end else begin
        count <= up ? count + W'(1) : count - W'(1);
      end
    end
  end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Four counter builds driven by shared stimulus:
//   0: N=4 DIV=1 WRAP   1: N=4 DIV=1 SAT   2: N=3 DIV=1 WRAP   3: N=4 DIV=3 WRAP
module tb_modn_updown_counter;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [1:0] load_val;
  logic [3:0][1:0] cnt_got;
  logic [3:0]      tc_got;
  logic [3:0]      ovf_got;

  modn_updown_counter #(.N(4), .DIV(1), .MODE(MODE_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_got[0]), .tc(tc_got[0]), .ovf(ovf_got[0]));
  modn_updown_counter #(.N(4), .DIV(1), .MODE(MODE_SAT)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_got[1]), .tc(tc_got[1]), .ovf(ovf_got[1]));
  modn_updown_counter #(.N(3), .DIV(1), .MODE(MODE_WRAP)) u_n3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_got[2]), .tc(tc_got[2]), .ovf(ovf_got[2]));
  modn_updown_counter #(.N(4), .DIV(3), .MODE(MODE_WRAP)) u_div (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_got[3]), .tc(tc_got[3]), .ovf(ovf_got[3]));

  typedef struct packed {
    logic [3:0][1:0] cnt;
    logic [3:0]      ovf;
    logic [3:0]      tc;
    logic [3:0]      tc_seen;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int n_of[4]   = '{4, 4, 3, 4};
  int div_of[4] = '{1, 1, 1, 3};
  bit sat_of[4] = '{0, 1, 0, 0};
  int m_cnt[4];
  int m_pre[4];
  bit m_ovf[4];

  // Reference model: samples tc before the edge, advances model state and
  // queues what each build must show after the edge.
  task automatic tick();
    exp_t e;
    bit   stp, at_end;
    #1;
    e.tc_seen = tc_got;
    for (int k = 0; k < 4; k++) begin
      e.tc[k] = 1'b0;
      if (!rst) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) > n_of[k] - 1) ? n_of[k] - 1 : int'(load_val);
        m_pre[k] = 0; m_ovf[k] = 0;
      end else begin
        stp    = en && (m_pre[k] == div_of[k] - 1);
        at_end = up ? (m_cnt[k] == n_of[k] - 1) : (m_cnt[k] == 0);
        e.tc[k] = stp && at_end;
        if (en) m_pre[k] = (m_pre[k] + 1) % div_of[k];
        if (stp) begin
          if (at_end) begin
            m_ovf[k] = 1;
            if (!sat_of[k]) m_cnt[k] = up ? 0 : n_of[k] - 1;
          end else begin
            m_cnt[k] = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
          end
        end
      end
      e.cnt[k] = 2'(m_cnt[k]);
      e.ovf[k] = m_ovf[k];
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic e, input logic u,
                        input logic l, input logic [1:0] lv);
    rst = r; en = e; up = u; load = l; load_val = lv;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== 2'd0 || ovf_got[k] !== 1'b0 || e.tc_seen[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset inst%0d: count=%0d ovf=%b tc=%b, want 0/0/0",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k]);
        end
      end
    end
  endtask

  task automatic test_count_up();
    exp_t e;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (cnt_got[0] !== 2'(i % 4) || ovf_got[0] !== (i >= 4)) begin
        miscompares++;
        $display("FAIL up_seq edge%0d: count=%0d ovf=%b, want %0d/%b",
                 i, cnt_got[0], ovf_got[0], i % 4, i >= 4);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL count_up inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  task automatic test_count_down();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, (i < 5), 1'b0, 1'b0, 2'd0);
      tick();
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL count_down inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int   sat_seq[6] = '{1, 2, 3, 3, 3, 3};
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    void'(sb_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (cnt_got[1] !== 2'(sat_seq[i]) || ovf_got[1] !== (i >= 3) || e.tc_seen[1] !== (i >= 3)) begin
        miscompares++;
        $display("FAIL sat_seq edge%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                 i, cnt_got[1], ovf_got[1], e.tc_seen[1], sat_seq[i], i >= 3, i >= 3);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL saturate inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic       ld[7] = '{1, 1, 0, 0, 0, 0, 1};
    logic       ens[7] = '{1, 0, 1, 1, 1, 1, 0};
    logic [1:0] lv[7] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, ens[i], 1'b1, ld[i], lv[i]);
      tick();
      e = sb_q.pop_front();
      if (i == 1) begin
        vectors++;
        if (cnt_got[2] !== 2'd2 || cnt_got[0] !== 2'd3 || ovf_got !== 4'b0000) begin
          miscompares++;
          $display("FAIL load_clamp: n3=%0d n4=%0d ovf=%b, want 2/3/0000",
                   cnt_got[2], cnt_got[0], ovf_got);
        end
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL load inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    logic ens[15] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    void'(sb_q.pop_front());
    for (int i = 0; i < 15; i++) begin
      set_in(1'b1, ens[i], 1'b1, 1'b0, 2'd0);
      tick();
      e = sb_q.pop_front();
      if (i < 9) begin
        vectors++;
        if (cnt_got[3] !== 2'((i + 1) / 3)) begin
          miscompares++;
          $display("FAIL div3_seq edge%0d: count=%0d, want %0d", i, cnt_got[3], (i + 1) / 3);
        end
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL prescale inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    void'(sb_q.pop_front());
    for (int i = 0; i < 11; i++) begin
      // Seven enabled edges leave the DIV=3 build at count=2, pre=1.
      set_in((i != 7), 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      e = sb_q.pop_front();
      if (i == 7) begin
        vectors++;
        if (cnt_got !== 8'h00 || ovf_got !== 4'b0000 || e.tc_seen !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_mid: count=%h ovf=%b tc=%b, want 00/0000/0000",
                   cnt_got, ovf_got, e.tc_seen);
        end
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL reset_mid inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      set_in(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
             1'($urandom), ($urandom_range(0, 9) == 0), 2'($urandom));
      tick();
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cnt_got[k] !== e.cnt[k] || ovf_got[k] !== e.ovf[k] || e.tc_seen[k] !== e.tc[k]) begin
          miscompares++;
          $display("FAIL random%0d inst%0d: count=%0d ovf=%b tc=%b, want %0d/%b/%b",
                   i, k, cnt_got[k], ovf_got[k], e.tc_seen[k], e.cnt[k], e.ovf[k], e.tc[k]);
        end
      end
    end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_prescale();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
